wb_slave_mem_bfm: RTL

Parametrised Wishbone classic slave BFM backed by an internal word-addressed memory. It replaces the tie-off slave, which always drives ACK/ERR/DAT_R low. This block adds real read/write storage, per-byte SEL masking, programmable wait states, address-range and injected error responses, and transfer counters. It connects to any `wb_if.slave` modport in a testbench or in synthesizable bring-up fabric.

---
 rtl/wb_slave_mem_bfm_pkg.sv | 23 ++
 rtl/wb_slave_mem_bfm_if.sv | 27 ++
 rtl/wb_slave_mem_bfm_ram.sv | 26 ++
 rtl/wb_slave_mem_bfm.sv | 138 +++++++++++++
 4 files changed

// File: rtl/wb_slave_mem_bfm_pkg.sv
// Shared types and helpers for the Wishbone slave memory BFM.
package wb_slave_mem_bfm_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned CntWidth = 32;

  // Lane-wise merge for up to 64-bit words; callers zero-extend narrower buses.
  function automatic logic [63:0] byte_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  sel);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_slave_mem_bfm_if.sv
// Wishbone classic bus bundle with master and slave views.
interface wb_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic                    ack;
  logic                    err;
  logic [DATA_WIDTH-1:0]   dat_r;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  ack, err, dat_r
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output ack, err, dat_r
  );

endinterface

// File: rtl/wb_slave_mem_bfm_ram.sv
// Single-port byte-enable RAM: synchronous write, asynchronous read, no reset.
module wb_slave_mem_bfm_ram
  import wb_slave_mem_bfm_pkg::*;
#(
  parameter int unsigned Depth     = 16,
  parameter int unsigned DataWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [DataWidth/8-1:0]   sel_i,
  output logic [DataWidth-1:0]     rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= DataWidth'(byte_merge(64'(mem_q[addr_i]), 64'(wdata_i), 8'(sel_i)));
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/wb_slave_mem_bfm.sv
// Wishbone classic slave BFM: word memory, wait states, range/injected errors, counters.
module wb_slave_mem_bfm
  import wb_slave_mem_bfm_pkg::*;
#(
  parameter int unsigned     WB_ADDR_WIDTH = 32,
  parameter int unsigned     WB_DATA_WIDTH = 32,
  parameter int unsigned     MEM_DEPTH     = 1024,
  parameter longint unsigned BASE_ADDR     = 0,
  parameter int unsigned     MAX_WAIT      = 15
) (
  input  logic                          clk,
  input  logic                          rst,
  wb_if.slave                           slave,
  input  logic [$clog2(MAX_WAIT+1)-1:0] wait_cycles,
  input  logic                          err_inject,
  output logic [CntWidth-1:0]           rd_count,
  output logic [CntWidth-1:0]           wr_count,
  output logic [CntWidth-1:0]           err_count
);

  localparam int unsigned ByteBits = $clog2(WB_DATA_WIDTH / 8);
  localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
  localparam int unsigned WaitW    = $clog2(MAX_WAIT + 1);
  localparam int unsigned SelW     = WB_DATA_WIDTH / 8;
  localparam logic [63:0] LoAddr   = 64'(BASE_ADDR);
  localparam logic [63:0] HiAddr   = LoAddr + 64'(MEM_DEPTH) * 64'(SelW);

  state_e                   state_q;
  logic [WaitW-1:0]         cnt_q;
  logic [IdxW-1:0]          idx_q;
  logic                     we_q;
  logic                     is_err_q;
  logic [SelW-1:0]          sel_q;
  logic [WB_DATA_WIDTH-1:0] wdata_q;
  logic                     ack_q;
  logic                     err_q;
  logic [WB_DATA_WIDTH-1:0] dat_r_q;
  logic [CntWidth-1:0]      rd_count_q;
  logic [CntWidth-1:0]      wr_count_q;
  logic [CntWidth-1:0]      err_count_q;

  logic [63:0]              adr_ext;
  logic                     in_range;
  logic [WaitW-1:0]         wait_clamped;
  logic [IdxW-1:0]          idx_d;
  logic                     ram_we;
  logic [WB_DATA_WIDTH-1:0] ram_rdata;

  always_comb begin
    adr_ext      = 64'(slave.adr);
    in_range     = (adr_ext >= LoAddr) && (adr_ext < HiAddr);
    wait_clamped = (wait_cycles > WaitW'(MAX_WAIT)) ? WaitW'(MAX_WAIT) : wait_cycles;
    idx_d        = IdxW'((slave.adr - WB_ADDR_WIDTH'(BASE_ADDR)) >> ByteBits);
  end

  // Commit happens on the same edge that raises ACK; reset suppresses it.
  assign ram_we = (state_q == StResp) && we_q && !is_err_q && !rst;

  wb_slave_mem_bfm_ram #(
    .Depth     (MEM_DEPTH),
    .DataWidth (WB_DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .sel_i   (sel_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      is_err_q    <= 1'b0;
      sel_q       <= '0;
      wdata_q     <= '0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_r_q     <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_r_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (slave.cyc && slave.stb) begin
            idx_q    <= idx_d;
            we_q     <= slave.we;
            sel_q    <= slave.sel;
            wdata_q  <= slave.dat_w;
            is_err_q <= err_inject || !in_range;
            cnt_q    <= wait_clamped;
            state_q  <= (wait_clamped == '0) ? StResp : StWait;
          end
        end
        StWait: begin
          if (!slave.cyc) begin
            state_q <= StIdle;
          end else if (cnt_q == WaitW'(1)) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - WaitW'(1);
          end
        end
        StResp: begin
          state_q <= StIdle;
          if (is_err_q) begin
            err_q       <= 1'b1;
            err_count_q <= err_count_q + 1'b1;
          end else begin
            ack_q <= 1'b1;
            if (we_q) begin
              wr_count_q <= wr_count_q + 1'b1;
            end else begin
              rd_count_q <= rd_count_q + 1'b1;
              dat_r_q    <= ram_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign slave.ack   = ack_q;
  assign slave.err   = err_q;
  assign slave.dat_r = dat_r_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign err_count   = err_count_q;

endmodule
